// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Receive-side decoder for the two-digit multiplexed seven-segment bus.
//   The incoming segment word is debounced. Each newly stable pattern is
//   decoded back to a hex nibble. A high digit followed by a low digit is
//   reassembled into the original byte.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   seg_in[7:0]  in   [7]=1 high digit / 0 low digit, [6:0]=segments a..g (1=lit)
//   data_out     out  last reassembled byte
//   data_valid   out  one-cycle pulse when data_out updates
//   data_changed out  one-cycle pulse with data_valid when the byte differs
//                     from the previous one, or it is the first since reset
//   err_invalid  out  one-cycle pulse: accepted pattern not in decode table
//   err_timeout  out  one-cycle pulse: low digit missing after a high digit
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       data_changed,
    output logic       err_invalid,
    output logic       err_timeout
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SCW-1:0] STABLE_MAX = SCW'(STABLE_CYCLES);
    localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        SYNC   = 1'b0,
        GOT_HI = 1'b1
    } state_t;

    // Returns {valid, nibble} for a segment pattern a..g.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h7E:   r = {1'b1, 4'h0};
            7'h30:   r = {1'b1, 4'h1};
            7'h6D:   r = {1'b1, 4'h2};
            7'h79:   r = {1'b1, 4'h3};
            7'h33:   r = {1'b1, 4'h4};
            7'h5B:   r = {1'b1, 4'h5};
            7'h5F:   r = {1'b1, 4'h6};
            7'h70:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h7B:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h1F:   r = {1'b1, 4'hB};
            7'h4E:   r = {1'b1, 4'hC};
            7'h3D:   r = {1'b1, 4'hD};
            7'h4F:   r = {1'b1, 4'hE};
            7'h47:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Input stage state
    logic [7:0]     seg_q;
    logic [SCW-1:0] stab_cnt_q, stab_cnt_d;
    logic           stable_evt_q, stable_evt_d;

    // FSM / output state
    state_t         state_q, state_d;
    logic [3:0]     hi_nib_q, hi_nib_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic [7:0]     data_q, data_d;
    logic           have_data_q, have_data_d;
    logic           dv_q, dv_d;
    logic           dc_q, dc_d;
    logic           einv_q, einv_d;
    logic           eto_q, eto_d;

    logic [4:0]     dec;
    logic [7:0]     new_byte;

    // Debounce: count consecutive identical samples; the event fires only on
    // the transition into saturation so a held word never re-fires.
    always_comb begin
        stab_cnt_d = SCW'(1);
        if (seg_in == seg_q) begin
            if (stab_cnt_q == STABLE_MAX) begin
                stab_cnt_d = stab_cnt_q;
            end else begin
                stab_cnt_d = stab_cnt_q + SCW'(1);
            end
        end
        stable_evt_d = (stab_cnt_d == STABLE_MAX) && (stab_cnt_q != STABLE_MAX);
    end

    // seg_q still holds the stable word on the edge after stable_evt is set.
    assign dec      = seg_decode(seg_q[6:0]);
    assign new_byte = {hi_nib_q, dec[3:0]};

    always_comb begin
        state_d     = state_q;
        hi_nib_d    = hi_nib_q;
        tcnt_d      = tcnt_q;
        data_d      = data_q;
        have_data_d = have_data_q;
        dv_d        = 1'b0;
        dc_d        = 1'b0;
        einv_d      = 1'b0;
        eto_d       = 1'b0;

        case (state_q)
            SYNC: begin
                if (stable_evt_q) begin
                    if (!dec[4]) begin
                        einv_d = 1'b1;
                    end else if (seg_q[7]) begin
                        hi_nib_d = dec[3:0];
                        tcnt_d   = '0;
                        state_d  = GOT_HI;
                    end
                    // A valid low digit without a preceding high digit is
                    // dropped: byte alignment is not yet known.
                end
            end
            GOT_HI: begin
                tcnt_d = tcnt_q + TCW'(1);
                // A stable event takes priority over timeout expiry.
                if (stable_evt_q) begin
                    if (!dec[4]) begin
                        einv_d  = 1'b1;
                        state_d = SYNC;
                    end else if (seg_q[7]) begin
                        hi_nib_d = dec[3:0];
                        tcnt_d   = '0;
                    end else begin
                        data_d      = new_byte;
                        dv_d        = 1'b1;
                        dc_d        = !have_data_q || (new_byte != data_q);
                        have_data_d = 1'b1;
                        state_d     = SYNC;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    eto_d   = 1'b1;
                    state_d = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q        <= 8'h00;
            stab_cnt_q   <= '0;
            stable_evt_q <= 1'b0;
            state_q      <= SYNC;
            hi_nib_q     <= 4'h0;
            tcnt_q       <= '0;
            data_q       <= 8'h00;
            have_data_q  <= 1'b0;
            dv_q         <= 1'b0;
            dc_q         <= 1'b0;
            einv_q       <= 1'b0;
            eto_q        <= 1'b0;
        end else begin
            seg_q        <= seg_in;
            stab_cnt_q   <= stab_cnt_d;
            stable_evt_q <= stable_evt_d;
            state_q      <= state_d;
            hi_nib_q     <= hi_nib_d;
            tcnt_q       <= tcnt_d;
            data_q       <= data_d;
            have_data_q  <= have_data_d;
            dv_q         <= dv_d;
            dc_q         <= dc_d;
            einv_q       <= einv_d;
            eto_q        <= eto_d;
        end
    end

    assign data_out     = data_q;
    assign data_valid   = dv_q;
    assign data_changed = dc_q;
    assign err_invalid  = einv_q;
    assign err_timeout  = eto_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture: directed scenarios plus randomized segment
// words, checked by a scoreboard fed from a cycle-level reference model.
module tb_seven_seg_capture;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_in;
    logic [7:0] data_out;
    logic       data_valid, data_changed, err_invalid, err_timeout;

    seven_seg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .data_out(data_out),
        .data_valid(data_valid), .data_changed(data_changed),
        .err_invalid(err_invalid), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Segment patterns for hex digits 0..F.
    logic [6:0] seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    typedef struct {
        int         cyc;
        logic [3:0] flags;   // {data_valid, data_changed, err_invalid, err_timeout}
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];

    // ---------------- reference model (one step per clock edge) ----------------
    int         cyc = 0;
    logic [7:0] m_prev;
    int         m_run;
    bit         m_pend;
    logic [7:0] m_pend_w;
    bit         m_have_hi;
    int         m_hi_edge;
    logic [3:0] m_hi;
    bit         m_have_data;
    logic [7:0] m_data;

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (seg_tbl[i] == s) return i;
        return -1;
    endfunction

    task automatic push(input logic [3:0] f, input logic [7:0] d);
        ev_t e;
        e.cyc = cyc; e.flags = f; e.data = d;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        int n;
        logic [7:0] b;
        cyc++;
        if (rst) begin
            m_prev = 8'h00; m_run = 0; m_pend = 0; m_have_hi = 0;
            m_have_data = 0; m_data = 8'h00;
        end else begin
            if (m_pend) begin
                n = lookup(m_pend_w[6:0]);
                if (n < 0) begin
                    push(4'b0010, m_data);
                    m_have_hi = 0;
                end else if (m_pend_w[7]) begin
                    m_hi = 4'(n); m_have_hi = 1; m_hi_edge = cyc;
                end else if (m_have_hi) begin
                    b = {m_hi, 4'(n)};
                    push({1'b1, (!m_have_data || b != m_data), 2'b00}, b);
                    m_data = b; m_have_data = 1; m_have_hi = 0;
                end
            end else if (m_have_hi && cyc == m_hi_edge + TIMEOUT) begin
                push(4'b0001, m_data);
                m_have_hi = 0;
            end
            if (seg_in == m_prev) m_run++;
            else m_run = 1;
            m_prev   = seg_in;
            m_pend   = (m_run == STABLE);
            m_pend_w = seg_in;
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [3:0] obs, expf;
        #2;
        obs  = {data_valid, data_changed, err_invalid, err_timeout};
        expf = 4'b0000;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("stale_event_cycle", exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            expf = exp_q[0].flags;
            void'(exp_q.pop_front());
        end
        chk("pulses", {28'd0, obs}, {28'd0, expf});
        chk("data_out", {24'd0, data_out}, {24'd0, m_data});
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [7:0] w, input int n);
        seg_in = w;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int sel, len;
        logic [7:0] w;
        rst = 1'b1;
        seg_in = 8'hFE;
        repeat (3) @(negedge clk);
        chk("reset_data_out", {24'd0, data_out}, 32'h0);
        chk("reset_pulses", {28'd0, data_valid, data_changed, err_invalid, err_timeout}, 32'h0);
        rst = 1'b0;

        // "0" high, "1" low -> 0x01
        hold(8'hFE, 32); hold(8'h30, 32);
        chk("byte_01", {24'd0, data_out}, 32'h01);

        // 0xA5 three times
        repeat (3) begin hold(8'hF7, 32); hold(8'h5B, 32); end
        chk("byte_A5", {24'd0, data_out}, 32'hA5);

        // glitch inside the low digit
        hold(8'hFE, 32); hold(8'h30, 2); hold(8'h00, 1); hold(8'h30, 32);

        // "-" on the high digit
        hold(8'h81, 8); hold(8'h81, 24);
        chk("after_invalid", {24'd0, data_out}, 32'h01);

        // high digit then frozen bus -> timeout; lone low digit is dropped
        hold(8'hB0, 300); hold(8'h30, 32);

        // reset while in GOT_HI
        hold(8'hB3, 32);
        seg_in = 8'h33; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold(8'h33, 32);
        hold(8'hB3, 32); hold(8'h33, 32);
        chk("byte_44", {24'd0, data_out}, 32'h44);

        // randomized segment words and hold lengths
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 5);
            if (sel <= 1)      w = {1'b1, seg_tbl[$urandom_range(0, 15)]};
            else if (sel <= 3) w = {1'b0, seg_tbl[$urandom_range(0, 15)]};
            else               w = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       len = 1;
                1:       len = 2;
                2:       len = STABLE - 1;
                3:       len = STABLE;
                4:       len = STABLE + 1;
                5:       len = ($urandom_range(0, 3) == 0) ? TIMEOUT + 20 : 40;
                default: len = $urandom_range(6, 32);
            endcase
            hold(w, len);
        end
        hold(8'h55, 20);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side decoder for the team's two-digit multiplexed seven-segment bus. Bit 7 selects the digit; bits 6:0 carry segments a..g, active-high.
- Watches the 8-bit segment word and debounces it.
- Decodes each stable pattern back to a hex nibble and reassembles the high/low digit pair into the original byte.
- Used in loopback self-test and as a bus monitor beside the display driver.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a segment word is accepted (min 2).
- TIMEOUT_CYCLES, 256, maximum cycles allowed in GOT_HI before the low digit is accepted (min 2).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- seg_in  input  8  segment bus; [7]=1 high digit, [7]=0 low digit; [6:0]=a..g, 1=lit
- data_out  output  8  last reassembled byte
- data_valid  output  1  one-cycle pulse when data_out updates
- data_changed  output  1  one-cycle pulse coincident with data_valid when the new byte differs from the previous one, or it is the first byte since reset
- err_invalid  output  1  one-cycle pulse: accepted pattern is not in the decode table
- err_timeout  output  1  one-cycle pulse: low digit not accepted within TIMEOUT_CYCLES

Behaviour:
- One clock domain: clk. rst is asynchronous and active-high.
- Reset clears all state and outputs: data_out=0x00, all pulses 0, state SYNC, counters 0, seg_q=0x00, have_data=0.
- rst asserted mid-operation aborts any partial byte. No pulse is emitted on reset or on the release of reset.

Input stage:
- seg_q registers seg_in every edge.
- stab_cnt, $clog2(STABLE_CYCLES+1) bits:
  - if seg_in==seg_q: increment, saturating at STABLE_CYCLES;
  - otherwise: load 1.
- stable_evt is a registered one-cycle pulse, set on the edge where stab_cnt becomes STABLE_CYCLES. It fires exactly once per run of identical words; a held word never re-fires.

Decode table, [6:0] to nibble:
- 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7
- 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F
- Any other value, including 0x01 ("-"), is invalid.

FSM, acting on the edge after stable_evt; all outputs are registered:
- SYNC:
  - valid high digit: hi_nib←nibble, timeout counter←0, go to GOT_HI.
  - valid low digit: ignored (no byte alignment yet).
  - invalid pattern: err_invalid pulse, stay in SYNC.
- GOT_HI:
  - timeout counter increments every cycle.
  - valid low digit: data_out←{hi_nib,nibble}, data_valid pulse, data_changed per definition, have_data←1, go to SYNC.
  - valid high digit: re-capture hi_nib, clear timeout counter, stay in GOT_HI.
  - invalid pattern: err_invalid pulse, go to SYNC.
  - timeout counter reaching TIMEOUT_CYCLES-1 with no stable_evt: err_timeout pulse, go to SYNC.
- If stable_evt and timeout expiry occur in the same cycle, stable_evt wins and err_timeout is not pulsed.

Latency:
- A low digit presented before edge 1 and held is accepted at edge STABLE_CYCLES+1.
- data_valid is high for the cycle following that edge: edge 5 with the default parameters.
- No pulse is ever wider than 1 cycle.

Test Plan:
- Hold 0xFE (high "3"? no: bit7=1, 7E="0") for 32 cycles, then 0x30 ("1") for 32 cycles → data_out=0x01, data_valid and data_changed each pulse once.
- Drive the display-driver pattern for byte 0xA5 (0xF7 then 0x5B, 32 cycles each) repeated 3 times → three data_valid pulses of 0xA5; data_changed pulses only on the first.
- Glitch: during the low digit, a single-cycle 0x00 between 0x30 words → run restarts; exactly one data_valid, value unchanged; no err_invalid, because 0x00 never reaches stable.
- Hold 0x81 ("-" on high digit) for 8 cycles → one err_invalid pulse, state SYNC, data_out unchanged.
- High digit 0xB0 then seg_in frozen → err_timeout exactly once, 256 cycles after GOT_HI entry. The following low digit alone produces no data_valid.
- Assert rst while in GOT_HI, then send low digit 0x33 → no output. A full pair 0xB3/0x33 afterwards gives data_out=0x44.
